// File: rtl/mem_pkg.sv
// Shared types for the store path: access size encoding and split FSM states.
package mem_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HALF  = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } split_state_t;

endpackage

// File: rtl/store_align.sv
// Combinational lane alignment for a store: positions the right-justified data
// and its byte mask inside a 16-byte window starting at the doubleword base.
module store_align
    import mem_pkg::*;
(
    input  logic [2:0]   i_off,
    input  mem_size_t    i_size,
    input  logic [63:0]  i_data,
    output logic [127:0] o_wide,
    output logic [15:0]  o_mask16,
    output logic         o_split
);

    logic [7:0]  byte_mask;
    logic [63:0] data_masked;

    always_comb begin
        byte_mask = 8'h01;
        case (i_size)
            BYTE:    byte_mask = 8'h01;
            HALF:    byte_mask = 8'h03;
            WORD:    byte_mask = 8'h0F;
            DWORD:   byte_mask = 8'hFF;
            default: byte_mask = 8'h01;
        endcase
    end

    // Bytes beyond the access size are cleared so they can never leak into a beat.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign data_masked[gi*8 +: 8] = i_data[gi*8 +: 8] & {8{byte_mask[gi]}};
        end
    endgenerate

    assign o_mask16 = {8'h00, byte_mask} << i_off;
    assign o_wide   = {64'd0, data_masked} << {i_off, 3'b000};
    assign o_split  = |o_mask16[15:8];

endmodule

// File: rtl/store_split_unit.sv
// Breaks one store of 1/2/4/8 bytes into one or two doubleword-aligned write
// beats with byte strobes; holds the requester off while beats are pending.
module store_split_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_data,
    input  logic [1:0]            i_req_size,
    output logic                  o_mem_valid,
    input  logic                  i_mem_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    output logic [7:0]            o_mem_strb,
    output logic                  o_mem_last,
    output logic                  o_done
);

    split_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
    mem_size_t             req_size_q, req_size_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic [7:0]            mem_strb_q, mem_strb_d;
    logic                  mem_last_q, mem_last_d;
    logic                  done_q, done_d;

    logic                  idle;
    logic [2:0]            al_off;
    mem_size_t             al_size;
    logic [DATA_WIDTH-1:0] al_data;
    logic [127:0]          al_wide;
    logic [15:0]           al_mask16;
    logic                  al_split;
    logic [ADDR_WIDTH-1:0] lo_addr_in;
    logic [ADDR_WIDTH-1:0] hi_addr;

    assign idle = (state_q == IDLE);

    // In IDLE the aligner sees the incoming request so the LOW beat can be
    // registered on the accepting edge; afterwards it sees the latched copy.
    assign al_off  = idle ? i_req_addr[2:0]          : req_addr_q[2:0];
    assign al_size = idle ? mem_size_t'(i_req_size) : req_size_q;
    assign al_data = idle ? i_req_data               : req_data_q;

    store_align u_align (
        .i_off    (al_off),
        .i_size   (al_size),
        .i_data   (al_data),
        .o_wide   (al_wide),
        .o_mask16 (al_mask16),
        .o_split  (al_split)
    );

    assign lo_addr_in = {i_req_addr[ADDR_WIDTH-1:3], 3'b000};
    assign hi_addr    = {req_addr_q[ADDR_WIDTH-1:3], 3'b000} + ADDR_WIDTH'(8);

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_size_d  = req_size_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_strb_d  = mem_strb_q;
        mem_last_d  = mem_last_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    req_addr_d  = i_req_addr;
                    req_data_d  = i_req_data;
                    req_size_d  = mem_size_t'(i_req_size);
                    state_d     = LOW;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = lo_addr_in;
                    mem_data_d  = al_wide[63:0];
                    mem_strb_d  = al_mask16[7:0];
                    mem_last_d  = !al_split;
                end
            end
            LOW: begin
                if (i_mem_ready) begin
                    if (al_split) begin
                        state_d    = HIGH;
                        mem_addr_d = hi_addr;
                        mem_data_d = al_wide[127:64];
                        mem_strb_d = al_mask16[15:8];
                        mem_last_d = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        mem_valid_d = 1'b0;
                        mem_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (i_mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    mem_last_d  = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
                mem_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_size_q  <= BYTE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_strb_q  <= '0;
            mem_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_size_q  <= req_size_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_strb_q  <= mem_strb_d;
            mem_last_q  <= mem_last_d;
            done_q      <= done_d;
        end
    end

    assign o_req_ready = idle;
    assign o_mem_valid = mem_valid_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_data  = mem_data_q;
    assign o_mem_strb  = mem_strb_q;
    assign o_mem_last  = mem_last_q;
    assign o_done      = done_q;

endmodule

// File: doc/store_split_unit.md
# store_split_unit

Store-side counterpart of the load-data assembly register. It accepts one store request of 1, 2, 4 or 8 bytes at any byte address. It converts the request into one or two 64-bit-aligned write beats, each with a byte strobe, so the data cache never sees a store that crosses a doubleword boundary. It sits between the core's memory stage and the data cache write port and holds the pipeline with `o_req_ready` while beats are outstanding.

## Interface
- `ADDR_WIDTH`, 64, byte address width.
- `DATA_WIDTH`, 64, store data and beat width. Only 64 is supported.
- `clk` in 1: clock.
- `arstn` in 1: reset, asynchronous, active-low.
- `i_req_valid` in 1: store request valid.
- `o_req_ready` out 1: unit can accept a request.
- `i_req_addr` in ADDR_WIDTH: byte address.
- `i_req_data` in 64: store data, right-justified.
- `i_req_size` in 2: access size. 0 = byte, 1 = half, 2 = word, 3 = dword.
- `o_mem_valid` out 1: write beat valid.
- `i_mem_ready` in 1: cache accepts the beat.
- `o_mem_addr` out ADDR_WIDTH: beat address. Bits [2:0] are always 0.
- `o_mem_data` out 64: beat data, byte-lane aligned.
- `o_mem_strb` out 8: beat byte enables.
- `o_mem_last` out 1: current beat is the final beat of the request.
- `o_done` out 1: one-cycle pulse when a request completes.

## Operation
- FSM states are IDLE, LOW and HIGH. `o_req_ready` = (state == IDLE).
- **Accept.** In IDLE, `i_req_valid & o_req_ready` latches addr, data and size, then moves to LOW. When not ready, `i_req_valid` is ignored and nothing is latched.
- **Beat computation.** Let off = addr[2:0] and n = 1 << size.
  - mask16 = ((1 << n) − 1) << off, 16 bits wide.
  - Data is zeroed above byte n−1, then shifted into a 128-bit vector wide = data << (8·off).
  - The request splits when mask16[15:8] ≠ 0.
- **LOW beat.**
  - `o_mem_addr` = {addr[ADDR_WIDTH−1:3], 3'b0}.
  - `o_mem_data` = wide[63:0].
  - `o_mem_strb` = mask16[7:0].
  - `o_mem_last` = !split.
- **HIGH beat.**
  - `o_mem_addr` = LOW address + 8, wrapping modulo 2^ADDR_WIDTH.
  - `o_mem_data` = wide[127:64].
  - `o_mem_strb` = mask16[15:8].
  - `o_mem_last` = 1.
- **Data masking.** Bytes of `o_mem_data` outside the strobe are always 0.
- **Transitions.**
  - LOW with `i_mem_ready`: go to HIGH if split, otherwise to IDLE.
  - HIGH with `i_mem_ready`: go to IDLE.
  - Without `i_mem_ready`, the state holds.
- **Beat stability.** While `o_mem_valid` is high and `i_mem_ready` is low, all `o_mem_*` outputs stay stable.
- **Completion.** `o_done` is registered. It pulses for one cycle in the cycle after the handshake of the final beat.
- **Split cases.**
  - Byte accesses never split.
  - Half splits only at off = 7.
  - Word splits at off ≥ 5.
  - Dword splits at any off ≠ 0.

## Timing
- **Reset values.**
  - State = IDLE, so `o_req_ready` = 1.
  - `o_mem_valid`, `o_mem_last` and `o_done` = 0.
  - `o_mem_addr`, `o_mem_data` and `o_mem_strb` = 0.
- **Beat outputs are registered.** A request accepted at edge T gives `o_mem_valid` = 1 in cycle T+1.
- **Non-split request, cache always ready:**
  - handshake in cycle T+1;
  - `o_done` and `o_req_ready` in cycle T+2.
- **Split request, cache always ready:**
  - beats in cycles T+1 and T+2;
  - `o_done` in cycle T+3.
- **Throughput.** A new request may be accepted in the same cycle `o_done` is high. Peak rate is one non-split store every 2 cycles.
- **Reset mid-operation.** Asserting `arstn` low abandons the request immediately. `o_mem_valid` drops asynchronously, no `o_done` is issued, and a partially written split store is not rolled back.
- **Interleaving.** No combinational path exists from `i_mem_ready` to `o_req_ready` beyond the state register.

## Structure
- Package `mem_pkg` holds:
  - `mem_size_t` enum (BYTE, HALF, WORD, DWORD = 0..3);
  - `split_state_t` enum (IDLE, LOW, HIGH).
- Sub-module `store_align` is purely combinational. It takes (off, size, data) and produces {wide[127:0], mask16[15:0], split}.
- The top level holds only the FSM, the request latch and the output registers.

## Test plan
- **Aligned dword.** Addr 0x1000, size 3, data 0x1122334455667788, ready held high.
  - One beat: addr 0x1000, strb 0xFF, data 0x1122334455667788, last = 1.
  - `o_done` 2 cycles after accept.
- **Misaligned dword.** Addr 0x1003, size 3, same data.
  - Beat 0: addr 0x1000, strb 0xF8, data 0x4455667788000000.
  - Beat 1: addr 0x1008, strb 0x07, data 0x0000000000112233, last = 1.
- **Half at off 7.** Addr 0x2007, size 1, data 0xFFFFFFFFFFFFABCD.
  - Beat 0: strb 0x80, data 0xCD00000000000000.
  - Beat 1: addr 0x2008, strb 0x01, data 0x00000000000000AB.
- **Back-pressure.** `i_mem_ready` low for 5 cycles during the LOW beat of a split store.
  - Outputs stay stable and `o_req_ready` = 0.
  - `i_req_valid` pulses during the stall are ignored.
  - HIGH beat follows release.
- **Wrap.** Addr 0xFFFF_FFFF_FFFF_FFFE, size 2.
  - Beat 0: addr 0xFFFF_FFFF_FFFF_FFF8, strb 0xC0.
  - Beat 1: addr 0x0, strb 0x03.
- **Reset mid-split.** Assert `arstn` during the HIGH beat.
  - `o_mem_valid` goes to 0 at once, no `o_done`, `o_req_ready` = 1.
  - The next request is processed normally.
